// File: rtl/fir_ch_scheduler.sv
// fir_ch_scheduler: round-robin sharing of one FIR engine between NUM_CH channels,
// with per-channel config slots, a fixed load/start sequence and a run watchdog.
module fir_ch_scheduler #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned TIMEOUT = 1024,
   localparam int unsigned CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   input  logic              cfg_wr,
   input  logic [CW-1:0]     cfg_ch,
   input  logic [ADDR_W-1:0] cfg_probki_base,
   input  logic [ADDR_W-1:0] cfg_wsp_base,
   input  logic [LEN_W-1:0]  cfg_len,
   output logic              fir_start,
   output logic              fir_abort,
   input  logic              fir_done,
   output logic [ADDR_W-1:0] fir_probki_base,
   output logic [ADDR_W-1:0] fir_wsp_base,
   output logic [LEN_W-1:0]  fir_len,
   output logic [NUM_CH-1:0] grant,
   output logic [NUM_CH-1:0] ch_done,
   output logic [NUM_CH-1:0] ch_err,
   output logic              pracuje
);

   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

   typedef struct packed {
      logic [ADDR_W-1:0] probki_base;
      logic [ADDR_W-1:0] wsp_base;
      logic [LEN_W-1:0]  len;
   } slot_t;

   typedef enum logic [2:0] {
      IDLE, ARB, LOAD, START_S, RUN, FINISH, ABORT
   } state_t;

   state_t            state_q, state_d;
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [CW-1:0]     rr_q, rr_d;
   logic [CW-1:0]     win_q, win_d;
   logic [WD_W-1:0]   wd_q, wd_d, wd_inc;
   slot_t             slots_q [NUM_CH];
   slot_t             fir_q, fir_d;
   logic [NUM_CH-1:0] grant_d, ch_done_d, ch_err_d;
   logic              fir_start_d, fir_abort_d, pracuje_d;
   logic [CW-1:0]     arb_idx;

   // Channel index base+off, wrapped modulo NUM_CH (both operands already < NUM_CH).
   function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base, input int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= NUM_CH) sum = sum - NUM_CH;
      return CW'(sum);
   endfunction

   function automatic logic [NUM_CH-1:0] onehot(input logic [CW-1:0] idx);
      logic [NUM_CH-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Round-robin pick: scan from the farthest offset down so the nearest pending channel wins.
   always_comb begin
      arb_idx = rr_q;
      for (int unsigned i = NUM_CH; i > 0; i--) begin
         if (pending_q[wrap_add(rr_q, i - 1)]) arb_idx = wrap_add(rr_q, i - 1);
      end
   end

   // Next-state and next-output logic; outputs are registered from these values.
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q | req;
      rr_d        = rr_q;
      win_d       = win_q;
      wd_d        = wd_q;
      wd_inc      = wd_q + WD_W'(1);
      fir_d       = fir_q;
      grant_d     = grant;
      fir_start_d = 1'b0;
      fir_abort_d = 1'b0;
      ch_done_d   = '0;
      ch_err_d    = '0;
      unique case (state_q)
         IDLE: begin
            if (|pending_q) begin
               state_d = ARB;
               win_d   = arb_idx;
               grant_d = onehot(arb_idx);
            end
         end
         ARB: begin
            // A fresh req from the winner in this cycle survives the clear.
            pending_d = (pending_q & ~onehot(win_q)) | req;
            state_d   = LOAD;
         end
         LOAD: begin
            fir_d = slots_q[win_q];
            if (slots_q[win_q].len == '0) begin
               state_d   = FINISH;
               ch_done_d = onehot(win_q);
            end else begin
               state_d     = START_S;
               fir_start_d = 1'b1;
            end
         end
         START_S: begin
            wd_d    = '0;
            state_d = RUN;
         end
         RUN: begin
            wd_d = wd_inc;
            if (fir_done) begin
               state_d   = FINISH;
               ch_done_d = onehot(win_q);
            end else if (wd_inc == WD_W'(TIMEOUT - 1)) begin
               state_d     = ABORT;
               fir_abort_d = 1'b1;
               ch_err_d    = onehot(win_q);
            end
         end
         FINISH, ABORT: begin
            state_d = IDLE;
            rr_d    = wrap_add(win_q, 1);
            grant_d = '0;
         end
         default: state_d = IDLE;
      endcase
      pracuje_d = (state_d != IDLE);
   end

   // State, control and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         rr_q      <= '0;
         win_q     <= '0;
         wd_q      <= '0;
         fir_q     <= '0;
         grant     <= '0;
         fir_start <= 1'b0;
         fir_abort <= 1'b0;
         ch_done   <= '0;
         ch_err    <= '0;
         pracuje   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         rr_q      <= rr_d;
         win_q     <= win_d;
         wd_q      <= wd_d;
         fir_q     <= fir_d;
         grant     <= grant_d;
         fir_start <= fir_start_d;
         fir_abort <= fir_abort_d;
         ch_done   <= ch_done_d;
         ch_err    <= ch_err_d;
         pracuje   <= pracuje_d;
      end
   end

   // Per-channel config slots; writes to out-of-range channels are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_CH; i++) slots_q[i] <= '0;
      end else if (cfg_wr && (32'(cfg_ch) < NUM_CH)) begin
         slots_q[cfg_ch] <= '{probki_base: cfg_probki_base,
                              wsp_base:    cfg_wsp_base,
                              len:         cfg_len};
      end
   end

   assign fir_probki_base = fir_q.probki_base;
   assign fir_wsp_base    = fir_q.wsp_base;
   assign fir_len         = fir_q.len;

endmodule

// File: tb/tb_fir_ch_scheduler.sv
// tb_fir_ch_scheduler: directed scenarios plus randomized runs against a run-level model.
module tb_fir_ch_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       cfg_wr;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_p, cfg_w, cfg_l;
   logic       done_drv;
   logic       sel_t;
   logic       fir_done_m, fir_done_t;

   logic       start_m, abort_m, prac_m, start_t, abort_t, prac_t;
   logic [7:0] pb_m, wb_m, len_m, pb_t, wb_t, len_t;
   logic [3:0] grant_m, done_m, err_m, grant_t, done_t, err_t;

   logic       o_start, o_abort, o_prac;
   logic [7:0] o_pb, o_wb, o_len;
   logic [3:0] o_grant, o_done, o_err;

   int checks   = 0;
   int failures = 0;

   // Run-level model: config slots, pending set and round-robin pointer.
   logic [7:0] m_p [4];
   logic [7:0] m_w [4];
   logic [7:0] m_l [4];
   logic [3:0] m_pend;
   int         m_rr;

   always #5 clk = ~clk;

   assign fir_done_m = done_drv & ~sel_t;
   assign fir_done_t = done_drv & sel_t;

   assign o_start = sel_t ? start_t : start_m;
   assign o_abort = sel_t ? abort_t : abort_m;
   assign o_prac  = sel_t ? prac_t  : prac_m;
   assign o_pb    = sel_t ? pb_t    : pb_m;
   assign o_wb    = sel_t ? wb_t    : wb_m;
   assign o_len   = sel_t ? len_t   : len_m;
   assign o_grant = sel_t ? grant_t : grant_m;
   assign o_done  = sel_t ? done_t  : done_m;
   assign o_err   = sel_t ? err_t   : err_m;

   fir_ch_scheduler #(.NUM_CH(4), .ADDR_W(8), .LEN_W(8), .TIMEOUT(1024)) dut (
      .clk(clk), .rst(rst), .req(req), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
      .cfg_probki_base(cfg_p), .cfg_wsp_base(cfg_w), .cfg_len(cfg_l),
      .fir_start(start_m), .fir_abort(abort_m), .fir_done(fir_done_m),
      .fir_probki_base(pb_m), .fir_wsp_base(wb_m), .fir_len(len_m),
      .grant(grant_m), .ch_done(done_m), .ch_err(err_m), .pracuje(prac_m));

   fir_ch_scheduler #(.NUM_CH(4), .ADDR_W(8), .LEN_W(8), .TIMEOUT(16)) dut_t (
      .clk(clk), .rst(rst), .req(req), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
      .cfg_probki_base(cfg_p), .cfg_wsp_base(cfg_w), .cfg_len(cfg_l),
      .fir_start(start_t), .fir_abort(abort_t), .fir_done(fir_done_t),
      .fir_probki_base(pb_t), .fir_wsp_base(wb_t), .fir_len(len_t),
      .grant(grant_t), .ch_done(done_t), .ch_err(err_t), .pracuje(prac_t));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_pend = '0;
      m_rr   = 0;
      for (int i = 0; i < 4; i++) begin
         m_p[i] = '0; m_w[i] = '0; m_l[i] = '0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; cfg_wr = 1'b0; done_drv = 1'b0;
      step();
      rst = 1'b0;
      model_reset();
   endtask

   // Drive a config write for the coming edge; the caller's next step commits it.
   task automatic drive_cfg(input int ch, input logic [7:0] p, input logic [7:0] w, input logic [7:0] l);
      cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_p = p; cfg_w = w; cfg_l = l;
      m_p[ch] = p; m_w[ch] = w; m_l[ch] = l;
   endtask

   task automatic cfg_write(input int ch, input logic [7:0] p, input logic [7:0] w, input logic [7:0] l);
      drive_cfg(ch, p, w, l);
      step();
      cfg_wr = 1'b0;
   endtask

   task automatic pulse_req(input logic [3:0] mask);
      req    = mask;
      m_pend = m_pend | mask;
   endtask

   function automatic int pick();
      for (int i = 0; i < 4; i++) begin
         int j;
         j = (m_rr + i) % 4;
         if (m_pend[j]) return j;
      end
      return -1;
   endfunction

   // One granted run: k = cycles after fir_start at which fir_done is driven.
   // A run without done by cycle TIMEOUT-1 of RUN must abort at fir_start + TIMEOUT.
   task automatic expect_run(input int k, input bit inj, input bit mid,
                             output logic [3:0] g, output logic [7:0] l0, output int lat);
      int         w, to, lim;
      bit         seen;
      logic [7:0] sp, sw, sl;
      logic [3:0] r;
      g = '0; l0 = '0; lat = 0;
      w = pick();
      if (w < 0) return;
      m_pend[w] = 1'b0;
      sp = m_p[w]; sw = m_w[w]; sl = m_l[w];
      seen = 1'b0;
      for (int n = 1; n <= 12 && !seen; n++) begin
         step();
         req = '0; cfg_wr = 1'b0;
         lat = n;
         if (o_start || (o_done != '0) || (o_err != '0)) seen = 1'b1;
      end
      chk("run_seen", 32'(seen), 32'd1);
      if (!seen) return;
      g  = o_grant;
      l0 = o_len;
      chk("grant", 32'(o_grant), 32'(1) << w);
      chk("busy", 32'(o_prac), 32'd1);
      if (sl == 8'd0) begin
         chk("zl_start", 32'(o_start), 32'd0);
         chk("zl_done", 32'(o_done), 32'(1) << w);
         chk("zl_err", 32'(o_err), 32'd0);
         m_rr = (w + 1) % 4;
         return;
      end
      chk("start", 32'(o_start), 32'd1);
      chk("probki", 32'(o_pb), 32'(sp));
      chk("wsp", 32'(o_wb), 32'(sw));
      chk("len", 32'(o_len), 32'(sl));
      to  = sel_t ? 16 : 1024;
      lim = (k <= to - 1) ? k : to - 1;
      for (int j = 1; j <= lim; j++) begin
         step();
         req = '0; cfg_wr = 1'b0;
         if (mid && j == 2) begin
            drive_cfg(1, 8'h10, 8'h40, 8'd9);
            pulse_req(4'b0010);
         end else if (inj) begin
            if ($urandom_range(0, 31) == 0) begin
               r = 4'($urandom_range(1, 15));
               pulse_req(r);
            end
            if ($urandom_range(0, 7) == 0)
               drive_cfg(int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom));
         end
         done_drv = (j == k);
      end
      step();
      req = '0; cfg_wr = 1'b0; done_drv = 1'b0;
      if (k <= to - 1) begin
         chk("ch_done", 32'(o_done), 32'(1) << w);
         chk("ch_err_quiet", 32'(o_err), 32'd0);
         chk("abort_quiet", 32'(o_abort), 32'd0);
      end else begin
         chk("ch_err", 32'(o_err), 32'(1) << w);
         chk("abort", 32'(o_abort), 32'd1);
         chk("ch_done_quiet", 32'(o_done), 32'd0);
      end
      chk("len_hold", 32'(o_len), 32'(sl));
      chk("grant_hold", 32'(o_grant), 32'(1) << w);
      m_rr = (w + 1) % 4;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout checks=%0d", checks);
      $fatal(1, "bench did not finish");
   end

   initial begin
      logic [3:0] g;
      logic [7:0] l0;
      int         lat;
      logic [3:0] acc;
      bit         seen;

      rst = 1'b1; req = '0; cfg_wr = 1'b0; cfg_ch = '0;
      cfg_p = '0; cfg_w = '0; cfg_l = '0; done_drv = 1'b0; sel_t = 1'b0;
      model_reset();

      // Reset state.
      do_reset();
      chk("rst_start", 32'(start_m), 32'd0);
      chk("rst_grant", 32'(grant_m), 32'd0);
      chk("rst_busy", 32'(prac_m), 32'd0);
      chk("rst_len", 32'(len_m), 32'd0);

      // Single run on channel 1, done 20 cycles after start.
      cfg_write(1, 8'h10, 8'h40, 8'd5);
      pulse_req(4'b0010);
      expect_run(20, 1'b0, 1'b0, g, l0, lat);
      chk("t1_latency", 32'(lat), 32'd4);
      chk("t1_grant", 32'(g), 32'b0010);
      chk("t1_len", 32'(l0), 32'd5);
      step();
      chk("t1_idle", 32'(prac_m), 32'd0);
      chk("t1_grant_idle", 32'(grant_m), 32'd0);

      // Round-robin order from a simultaneous request.
      do_reset();
      for (int c = 0; c < 4; c++) cfg_write(c, 8'(c), 8'(c + 8), 8'd4);
      pulse_req(4'b1111);
      expect_run(3, 1'b0, 1'b0, g, l0, lat);
      chk("rr_0", 32'(g), 32'b0001);
      expect_run(3, 1'b0, 1'b0, g, l0, lat);
      chk("rr_1", 32'(g), 32'b0010);
      expect_run(3, 1'b0, 1'b0, g, l0, lat);
      chk("rr_2", 32'(g), 32'b0100);
      expect_run(3, 1'b0, 1'b0, g, l0, lat);
      chk("rr_3", 32'(g), 32'b1000);
      step();
      pulse_req(4'b0101);
      expect_run(2, 1'b0, 1'b0, g, l0, lat);
      chk("rr_wrap_a", 32'(g), 32'b0001);
      expect_run(2, 1'b0, 1'b0, g, l0, lat);
      chk("rr_wrap_b", 32'(g), 32'b0100);

      // Zero-length slot completes without starting the engine.
      do_reset();
      cfg_write(2, 8'h22, 8'h33, 8'd0);
      pulse_req(4'b0100);
      expect_run(1, 1'b0, 1'b0, g, l0, lat);
      chk("zl_latency", 32'(lat), 32'd4);
      chk("zl_grant", 32'(g), 32'b0100);

      // Config rewrite and re-request while the channel runs.
      do_reset();
      cfg_write(1, 8'h10, 8'h40, 8'd5);
      pulse_req(4'b0010);
      expect_run(6, 1'b0, 1'b1, g, l0, lat);
      chk("cw_first_len", 32'(l0), 32'd5);
      expect_run(4, 1'b0, 1'b0, g, l0, lat);
      chk("cw_second_len", 32'(l0), 32'd9);
      chk("cw_second_grant", 32'(g), 32'b0010);

      // Reset in the middle of a run with two channels pending.
      do_reset();
      cfg_write(0, 8'h01, 8'h02, 8'd5);
      cfg_write(1, 8'h03, 8'h04, 8'd5);
      cfg_write(3, 8'h05, 8'h06, 8'd5);
      req = 4'b0001;
      seen = 1'b0;
      for (int n = 0; n < 12 && !seen; n++) begin
         step();
         req = '0;
         if (start_m) seen = 1'b1;
      end
      chk("mr_started", 32'(seen), 32'd1);
      step();
      req = 4'b1010;
      step();
      req = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      chk("mr_start", 32'(start_m), 32'd0);
      chk("mr_abort", 32'(abort_m), 32'd0);
      chk("mr_grant", 32'(grant_m), 32'd0);
      chk("mr_done", 32'(done_m), 32'd0);
      chk("mr_err", 32'(err_m), 32'd0);
      chk("mr_busy", 32'(prac_m), 32'd0);
      chk("mr_fir", {8'd0, pb_m, wb_m, len_m}, 32'd0);
      acc = '0;
      for (int n = 0; n < 8; n++) begin
         step();
         acc = acc | {start_m, abort_m, (|done_m) | (|err_m), prac_m};
      end
      chk("mr_quiet", 32'(acc), 32'd0);
      pulse_req(4'b0010);
      expect_run(5, 1'b0, 1'b0, g, l0, lat);
      chk("mr_slot_cleared_lat", 32'(lat), 32'd4);
      chk("mr_slot_cleared_grant", 32'(g), 32'b0010);

      // Watchdog with TIMEOUT = 16, then done exactly at the timeout cycle.
      sel_t = 1'b1;
      do_reset();
      cfg_write(0, 8'hA0, 8'hB0, 8'd3);
      cfg_write(1, 8'hA1, 8'hB1, 8'd7);
      pulse_req(4'b0011);
      expect_run(99, 1'b0, 1'b0, g, l0, lat);
      chk("to_grant", 32'(g), 32'b0001);
      expect_run(4, 1'b0, 1'b0, g, l0, lat);
      chk("to_next_grant", 32'(g), 32'b0010);
      step();
      pulse_req(4'b0001);
      expect_run(15, 1'b0, 1'b0, g, l0, lat);
      step();
      pulse_req(4'b0001);
      expect_run(16, 1'b0, 1'b0, g, l0, lat);

      // fir_done while idle has no effect.
      step();
      step();
      done_drv = 1'b1;
      step();
      done_drv = 1'b0;
      step();
      chk("idle_done_busy", 32'(prac_t), 32'd0);
      chk("idle_done_pulse", 32'(done_t), 32'd0);

      // Randomized runs on the short-timeout instance.
      do_reset();
      for (int r = 0; r < 25; r++) begin
         int runs;
         for (int c = 0; c < 4; c++)
            cfg_write(c, 8'($urandom), 8'($urandom),
                      ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
         pulse_req(4'($urandom_range(1, 15)));
         runs = 0;
         while (m_pend != '0 && runs < 40) begin
            expect_run(int'($urandom_range(1, 20)), runs < 8, 1'b0, g, l0, lat);
            runs++;
         end
         step();
         step();
         chk("rand_idle", 32'(prac_t), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
